// File: rtl/ysyx_22041461_pkg.sv
// Shared definitions for the execute stage: default datapath width, operation
// encodings, FSM states and small decode helpers.
package ysyx_22041461_pkg;

    localparam int XLEN_DFLT = 64;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_MUL  = 4'd10,
        OP_DIV  = 4'd11,
        OP_DIVU = 4'd12,
        OP_REM  = 4'd13,
        OP_REMU = 4'd14
    } exe_op_e;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_DIV_BUSY = 1'b1
    } exe_state_e;

    function automatic logic op_is_div(input exe_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic op_is_signed_div(input exe_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input exe_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/ysyx_22041461_divider.sv
// Restoring unsigned divider, one quotient bit per cycle. The last iteration's
// quotient/remainder are exposed combinationally so the caller can register them on that edge.
module ysyx_22041461_divider
    import ysyx_22041461_pkg::*;
#(
    parameter int XLEN = XLEN_DFLT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            word,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CW = $clog2(XLEN + 1);

    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;

    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;
    logic            fits;
    logic [XLEN-1:0] rem_nxt;
    logic [XLEN-1:0] quo_nxt;

    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        trial   = shifted - {1'b0, dvs_q};
        fits    = !trial[XLEN];
        rem_nxt = fits ? trial[XLEN-1:0] : shifted[XLEN-1:0];
        quo_nxt = {quo_q[XLEN-2:0], fits};
    end

    assign busy      = (cnt_q != '0);
    assign done      = (cnt_q == CW'(1));
    assign quotient  = quo_nxt;
    assign remainder = rem_nxt;

    // Word divides park the 32-bit dividend in the top half so the same MSB-first shift works.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (start) begin
            cnt_q <= word ? CW'(32) : CW'(XLEN);
            rem_q <= '0;
            quo_q <= word ? {dividend[31:0], {(XLEN-32){1'b0}}} : dividend;
            dvs_q <= divisor;
        end else if (busy) begin
            cnt_q <= cnt_q - CW'(1);
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
        end
    end

endmodule

// File: rtl/ysyx_22041461_exe.sv
// Execute stage: single-cycle ALU/MUL plus an iterative divider, with a one-entry
// registered output and valid/ready handshakes on both sides.
//
//   state       | meaning
//   ST_IDLE     | accepting work; single-cycle results load the output register
//   ST_DIV_BUSY | divider iterating; no accept until the result lands
module ysyx_22041461_exe
    import ysyx_22041461_pkg::*;
#(
    parameter int XLEN = XLEN_DFLT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            EXE_valid_in,
    output logic            EXE_ready_out,
    input  logic [3:0]      EXE_op,
    input  logic            EXE_word,
    input  logic [XLEN-1:0] EXE_src1,
    input  logic [XLEN-1:0] EXE_src2,
    input  logic [4:0]      EXE_rd_in,
    input  logic            EXE_flush,
    input  logic            EXE_ready_in,
    output logic            EXE_valid_out,
    output logic [XLEN-1:0] EXE_result,
    output logic [4:0]      EXE_rd_out
);

    function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] v);
        return {{(XLEN-32){v[31]}}, v[31:0]};
    endfunction

    exe_state_e      state_q;
    logic [4:0]      pend_rd_q;
    logic            pend_word_q;
    logic            pend_rem_q;
    logic            pend_neg_q_q;
    logic            pend_neg_r_q;

    exe_op_e         op;
    logic [XLEN-1:0] a_s, a_z, b_s, b_z;
    logic [XLEN-1:0] a_sel, b_sel, mag_a, mag_b, min_neg;
    logic [5:0]      sh;
    logic            is_div, div_signed, div_rem, div_zero, div_ovf, neg_a, neg_b;
    logic [XLEN-1:0] alu_raw, single_result;

    logic            accept, goes_busy;
    logic            div_busy, div_done;
    logic [XLEN-1:0] div_q, div_r, div_mag, div_val, div_result;
    logic            div_neg;

    always_comb begin
        op         = exe_op_e'(EXE_op);
        a_s        = EXE_word ? sext_word(EXE_src1) : EXE_src1;
        b_s        = EXE_word ? sext_word(EXE_src2) : EXE_src2;
        a_z        = EXE_word ? {{(XLEN-32){1'b0}}, EXE_src1[31:0]} : EXE_src1;
        b_z        = EXE_word ? {{(XLEN-32){1'b0}}, EXE_src2[31:0]} : EXE_src2;
        sh         = EXE_word ? {1'b0, EXE_src2[4:0]} : EXE_src2[5:0];

        is_div     = op_is_div(op);
        div_signed = op_is_signed_div(op);
        div_rem    = op_is_rem(op);
        a_sel      = div_signed ? a_s : a_z;
        b_sel      = div_signed ? b_s : b_z;
        min_neg    = EXE_word ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
        div_zero   = (b_sel == '0);
        div_ovf    = div_signed && (a_sel == min_neg) && (b_sel == '1);
        neg_a      = div_signed && a_sel[XLEN-1];
        neg_b      = div_signed && b_sel[XLEN-1];
        mag_a      = neg_a ? -a_sel : a_sel;
        mag_b      = neg_b ? -b_sel : b_sel;

        alu_raw = '0;
        case (op)
            OP_ADD:  alu_raw = EXE_src1 + EXE_src2;
            OP_SUB:  alu_raw = EXE_src1 - EXE_src2;
            OP_AND:  alu_raw = EXE_src1 & EXE_src2;
            OP_OR:   alu_raw = EXE_src1 | EXE_src2;
            OP_XOR:  alu_raw = EXE_src1 ^ EXE_src2;
            OP_SLL:  alu_raw = EXE_src1 << sh;
            OP_SRL:  alu_raw = a_z >> sh;
            OP_SRA:  alu_raw = $signed(a_s) >>> sh;
            OP_SLT:  alu_raw = {{(XLEN-1){1'b0}}, ($signed(a_s) < $signed(b_s))};
            OP_SLTU: alu_raw = {{(XLEN-1){1'b0}}, (a_z < b_z)};
            OP_MUL:  alu_raw = EXE_src1 * EXE_src2;
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
                if (div_zero)
                    alu_raw = div_rem ? a_sel : '1;
                else if (div_ovf)
                    alu_raw = div_rem ? '0 : a_sel;
            end
            default: alu_raw = '0;
        endcase
        single_result = EXE_word ? sext_word(alu_raw) : alu_raw;
    end

    assign EXE_ready_out = (state_q == ST_IDLE) && (!EXE_valid_out || EXE_ready_in) && !rst;
    assign accept        = EXE_valid_in && EXE_ready_out && !EXE_flush;
    assign goes_busy     = accept && is_div && !div_zero && !div_ovf;

    ysyx_22041461_divider #(.XLEN(XLEN)) u_divider (
        .clk       (clk),
        .rst       (rst),
        .start     (goes_busy),
        .abort     (EXE_flush),
        .word      (EXE_word),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    // Quotient sign follows sign mismatch, remainder follows the dividend.
    always_comb begin
        div_mag    = pend_rem_q ? div_r : div_q;
        div_neg    = pend_rem_q ? pend_neg_r_q : pend_neg_q_q;
        div_val    = div_neg ? -div_mag : div_mag;
        div_result = pend_word_q ? sext_word(div_val) : div_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            EXE_valid_out <= 1'b0;
            EXE_result    <= '0;
            EXE_rd_out    <= '0;
            pend_rd_q     <= '0;
            pend_word_q   <= 1'b0;
            pend_rem_q    <= 1'b0;
            pend_neg_q_q  <= 1'b0;
            pend_neg_r_q  <= 1'b0;
        end else if (EXE_flush) begin
            state_q       <= ST_IDLE;
            EXE_valid_out <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (goes_busy) begin
                        state_q       <= ST_DIV_BUSY;
                        EXE_valid_out <= 1'b0;
                        pend_rd_q     <= EXE_rd_in;
                        pend_word_q   <= EXE_word;
                        pend_rem_q    <= div_rem;
                        pend_neg_q_q  <= neg_a ^ neg_b;
                        pend_neg_r_q  <= neg_a;
                    end else if (accept) begin
                        EXE_valid_out <= 1'b1;
                        EXE_result    <= single_result;
                        EXE_rd_out    <= EXE_rd_in;
                    end else if (EXE_valid_out && EXE_ready_in) begin
                        EXE_valid_out <= 1'b0;
                    end
                end
                ST_DIV_BUSY: begin
                    if (div_done) begin
                        state_q       <= ST_IDLE;
                        EXE_valid_out <= 1'b1;
                        EXE_result    <= div_result;
                        EXE_rd_out    <= pend_rd_q;
                    end else if (!div_busy) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22041461_exe.sv
// Directed bench for the execute stage: ALU/MUL vectors, divide latency and
// special cases, backpressure, flush and reset abort.
module tb_ysyx_22041461_exe;
    import ysyx_22041461_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        EXE_valid_in;
    logic        EXE_ready_out;
    logic [3:0]  EXE_op;
    logic        EXE_word;
    logic [63:0] EXE_src1;
    logic [63:0] EXE_src2;
    logic [4:0]  EXE_rd_in;
    logic        EXE_flush;
    logic        EXE_ready_in;
    logic        EXE_valid_out;
    logic [63:0] EXE_result;
    logic [4:0]  EXE_rd_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  op;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        logic [3:0]  op;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          low;
    } dvec_t;

    ysyx_22041461_exe #(.XLEN(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .EXE_valid_in  (EXE_valid_in),
        .EXE_ready_out (EXE_ready_out),
        .EXE_op        (EXE_op),
        .EXE_word      (EXE_word),
        .EXE_src1      (EXE_src1),
        .EXE_src2      (EXE_src2),
        .EXE_rd_in     (EXE_rd_in),
        .EXE_flush     (EXE_flush),
        .EXE_ready_in  (EXE_ready_in),
        .EXE_valid_out (EXE_valid_out),
        .EXE_result    (EXE_result),
        .EXE_rd_out    (EXE_rd_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd);
        EXE_valid_in = 1'b1;
        EXE_op       = op;
        EXE_word     = w;
        EXE_src1     = a;
        EXE_src2     = b;
        EXE_rd_in    = rd;
    endtask

    task automatic test_reset();
        EXE_valid_in = 1'b1;
        EXE_op       = OP_ADD;
        EXE_word     = 1'b0;
        EXE_src1     = 64'd1;
        EXE_src2     = 64'd1;
        EXE_rd_in    = 5'd1;
        EXE_flush    = 1'b0;
        EXE_ready_in = 1'b1;
        rst          = 1'b1;
        tick();
        tick();
        total++;
        if (EXE_valid_out !== 1'b0 || EXE_result !== 64'd0 || EXE_rd_out !== 5'd0) begin
            bad++;
            $display("FAIL reset_outputs: valid=%b result=%h rd=%0d, want 0/0/0",
                     EXE_valid_out, EXE_result, EXE_rd_out);
        end
        total++;
        if (EXE_ready_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready: ready_out=%b want 0", EXE_ready_out);
        end
        EXE_valid_in = 1'b0;
        rst = 1'b0;
        #1;
        total++;
        if (EXE_ready_out !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: ready_out=%b want 1", EXE_ready_out);
        end
    endtask

    task automatic test_add();
        drive(OP_ADD, 1'b0, 64'd5, 64'd7, 5'd3);
        tick();
        EXE_valid_in = 1'b0;
        total++;
        if (EXE_valid_out !== 1'b1 || EXE_result !== 64'd12 || EXE_rd_out !== 5'd3) begin
            bad++;
            $display("FAIL add_basic: valid=%b result=%h rd=%0d, want 1/0xc/3",
                     EXE_valid_out, EXE_result, EXE_rd_out);
        end
        tick();
        total++;
        if (EXE_valid_out !== 1'b0) begin
            bad++;
            $display("FAIL add_handoff_clear: valid=%b want 0", EXE_valid_out);
        end
    endtask

    task automatic test_alu_vectors();
        vec_t v[25];
        v[0]  = '{OP_SUB,  1'b0, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE};
        v[1]  = '{OP_AND,  1'b0, 64'hF0F0, 64'hFF00, 64'hF000};
        v[2]  = '{OP_OR,   1'b0, 64'hF0F0, 64'hFF00, 64'hFFF0};
        v[3]  = '{OP_XOR,  1'b0, 64'hF0F0, 64'hFF00, 64'h0FF0};
        v[4]  = '{OP_SLL,  1'b0, 64'd1, 64'd63, 64'h8000_0000_0000_0000};
        v[5]  = '{OP_SLL,  1'b0, 64'd1, 64'd67, 64'd8};
        v[6]  = '{OP_SRL,  1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000};
        v[7]  = '{OP_SRA,  1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000};
        v[8]  = '{OP_SLT,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1};
        v[9]  = '{OP_SLTU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0};
        v[10] = '{OP_MUL,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD};
        v[11] = '{OP_MUL,  1'b0, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0};
        v[12] = '{OP_ADD,  1'b1, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000};
        v[13] = '{OP_SLL,  1'b1, 64'd1, 64'h21, 64'd2};
        v[14] = '{OP_SRL,  1'b1, 64'hFFFF_FFFF_8000_0000, 64'd4, 64'h0800_0000};
        v[15] = '{OP_SRA,  1'b1, 64'hFFFF_FFFF_8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000};
        v[16] = '{OP_SRL,  1'b1, 64'h8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000};
        v[17] = '{OP_DIVU, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
        v[18] = '{OP_REMU, 1'b0, 64'h1234, 64'd0, 64'h1234};
        v[19] = '{OP_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
        v[20] = '{OP_REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
        v[21] = '{OP_DIV,  1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000};
        v[22] = '{OP_DIVU, 1'b1, 64'h1234_5678, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
        v[23] = '{OP_REM,  1'b1, 64'h1234_5678, 64'd0, 64'h1234_5678};
        v[24] = '{OP_SUB,  1'b1, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF};
        EXE_ready_in = 1'b1;
        for (int i = 0; i < 25; i++) begin
            drive(v[i].op, v[i].w, v[i].a, v[i].b, 5'(i));
            tick();
            total++;
            if (EXE_valid_out !== 1'b1 || EXE_result !== v[i].exp || EXE_rd_out !== 5'(i)) begin
                bad++;
                $display("FAIL alu_vec[%0d] op=%0d w=%b: valid=%b result=%h rd=%0d, want 1/%h/%0d",
                         i, v[i].op, v[i].w, EXE_valid_out, EXE_result, EXE_rd_out, v[i].exp, i);
            end
        end
        EXE_valid_in = 1'b0;
        tick();
    endtask

    task automatic test_div_iterative();
        dvec_t d[5];
        int    low;
        int    n;
        d[0] = '{OP_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 64};
        d[1] = '{OP_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 64};
        d[2] = '{OP_DIVU, 1'b1, 64'hFFFF_FFFF_0000_0064, 64'd7, 64'h0E, 32};
        d[3] = '{OP_REM,  1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 32};
        d[4] = '{OP_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 64'h1999_9999_9999_9999, 64};
        EXE_ready_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(d[i].op, d[i].w, d[i].a, d[i].b, 5'(20 + i));
            tick();
            EXE_valid_in = 1'b0;
            low = 0;
            n   = 0;
            while (EXE_valid_out !== 1'b1 && n < 200) begin
                if (EXE_ready_out === 1'b0) low++;
                tick();
                n++;
            end
            total++;
            if (EXE_valid_out !== 1'b1) begin
                bad++;
                $display("FAIL div_timeout[%0d]: no result after %0d cycles", i, n);
            end
            total++;
            if (low != d[i].low) begin
                bad++;
                $display("FAIL div_busy_cycles[%0d]: ready low %0d cycles, want %0d", i, low, d[i].low);
            end
            total++;
            if (EXE_result !== d[i].exp || EXE_rd_out !== 5'(20 + i) || EXE_ready_out !== 1'b1) begin
                bad++;
                $display("FAIL div_result[%0d]: result=%h rd=%0d ready=%b, want %h/%0d/1",
                         i, EXE_result, EXE_rd_out, EXE_ready_out, d[i].exp, 20 + i);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        EXE_ready_in = 1'b0;
        drive(OP_ADD, 1'b0, 64'd1, 64'd2, 5'd9);
        tick();
        total++;
        if (EXE_valid_out !== 1'b1 || EXE_result !== 64'd3 || EXE_rd_out !== 5'd9) begin
            bad++;
            $display("FAIL bp_first: valid=%b result=%h rd=%0d, want 1/3/9",
                     EXE_valid_out, EXE_result, EXE_rd_out);
        end
        drive(OP_SUB, 1'b0, 64'd10, 64'd1, 5'd10);
        for (int c = 0; c < 3; c++) begin
            total++;
            if (EXE_valid_out !== 1'b1 || EXE_result !== 64'd3 || EXE_rd_out !== 5'd9 ||
                EXE_ready_out !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold[%0d]: valid=%b result=%h rd=%0d ready=%b, want 1/3/9/0",
                         c, EXE_valid_out, EXE_result, EXE_rd_out, EXE_ready_out);
            end
            tick();
        end
        EXE_ready_in = 1'b1;
        #1;
        total++;
        if (EXE_ready_out !== 1'b1) begin
            bad++;
            $display("FAIL bp_release_ready: ready=%b want 1", EXE_ready_out);
        end
        tick();
        EXE_valid_in = 1'b0;
        total++;
        if (EXE_valid_out !== 1'b1 || EXE_result !== 64'd9 || EXE_rd_out !== 5'd10) begin
            bad++;
            $display("FAIL bp_reload: valid=%b result=%h rd=%0d, want 1/9/10",
                     EXE_valid_out, EXE_result, EXE_rd_out);
        end
        tick();
        total++;
        if (EXE_valid_out !== 1'b0) begin
            bad++;
            $display("FAIL bp_drain: valid=%b want 0", EXE_valid_out);
        end
    endtask

    task automatic test_flush();
        logic seen;
        EXE_ready_in = 1'b1;
        drive(OP_DIV, 1'b0, 64'd1000, 64'd3, 5'd11);
        tick();
        EXE_valid_in = 1'b0;
        for (int c = 0; c < 9; c++) tick();
        EXE_flush = 1'b1;
        drive(OP_ADD, 1'b0, 64'd4, 64'd4, 5'd12);
        tick();
        EXE_flush    = 1'b0;
        EXE_valid_in = 1'b0;
        total++;
        if (EXE_valid_out !== 1'b0 || EXE_ready_out !== 1'b1) begin
            bad++;
            $display("FAIL flush_state: valid=%b ready=%b, want 0/1", EXE_valid_out, EXE_ready_out);
        end
        seen = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (EXE_valid_out === 1'b1) seen = 1'b1;
            tick();
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL flush_no_result: stray valid_out seen=%b want 0", seen);
        end
    endtask

    task automatic test_reset_mid_div();
        logic seen;
        EXE_ready_in = 1'b1;
        drive(OP_DIVU, 1'b0, 64'd77, 64'd5, 5'd13);
        tick();
        EXE_valid_in = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        rst = 1'b1;
        tick();
        total++;
        if (EXE_valid_out !== 1'b0 || EXE_ready_out !== 1'b0 || EXE_result !== 64'd0) begin
            bad++;
            $display("FAIL rst_mid_div: valid=%b ready=%b result=%h, want 0/0/0",
                     EXE_valid_out, EXE_ready_out, EXE_result);
        end
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (EXE_valid_out === 1'b1) seen = 1'b1;
            tick();
        end
        total++;
        if (seen !== 1'b0 || EXE_ready_out !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_div_abort: seen=%b ready=%b, want 0/1", seen, EXE_ready_out);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu_vectors();
        test_div_iterative();
        test_backpressure();
        test_flush();
        test_reset_mid_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
